seg7_scan_decoder: RTL and testbench

- Observes a time-multiplexed 7-segment display bus (active-low segments, active-low one-hot digit select) and recovers the hex value being shown.
- Inverse of the team's hex-to-7-segment encoder; it sits in the verification/loopback path and in the board self-test, reading back what the display driver emits.
- Debounces each digit slot, decodes the pattern to a nibble, and assembles a full multi-digit frame with validity and error flags.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_pattern_decode.sv | 41 ++++
 rtl/seg7_scan_decoder.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg : shared 7-segment pattern constants and scan-decoder FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

    // Active-low segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    typedef logic [0:0] scan_state_t;
    typedef logic [2:0] digit_idx_t;

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ---------------------------------------------------------------------------
// seg7_pattern_decode : active-low 7-segment pattern -> {valid, nibble}
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b1;
        nibble = 4'h0;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: valid  = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder : recovers the hex frame shown on a multiplexed display bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    output logic [4*NUM_DIGITS-1:0]   value_out,
    output logic                      frame_valid,
    output logic                      frame_err,
    output logic                      seq_err
);

    localparam int         SAMPLE_W   = 7 + NUM_DIGITS;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam digit_idx_t LAST_DIGIT = 3'(NUM_DIGITS - 1);

    logic [6:0]              seg_meta, seg_s;
    logic [NUM_DIGITS-1:0]   sel_meta, sel_s;
    logic [SAMPLE_W-1:0]     sample, prev_sample;
    logic [7:0]              stable_cnt;
    logic [3:0]              zero_cnt;
    logic                    sel_legal;
    digit_idx_t              sel_idx;
    logic                    capture;
    logic                    accept;
    logic                    pat_valid;
    logic [3:0]              pat_nibble;

    scan_state_t             state;
    digit_idx_t              expected;
    logic [4*NUM_DIGITS-1:0] digit_buf;
    logic                    bad;
    logic                    frame_done;

    // Synchronizers idle at all-ones: blank segments, no digit selected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta <= '1;
            seg_s    <= '1;
            sel_meta <= '1;
            sel_s    <= '1;
        end else begin
            seg_meta <= seg_in;
            seg_s    <= seg_meta;
            sel_meta <= dig_sel;
            sel_s    <= sel_meta;
        end
    end

    assign sample = {sel_s, seg_s};

    always_comb begin
        zero_cnt = 4'd0;
        sel_idx  = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_s[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                sel_idx  = 3'(i);
            end
        end
        sel_legal = (zero_cnt == 4'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sample <= '1;
            stable_cnt  <= 8'd0;
        end else begin
            prev_sample <= sample;
            if ((sample != prev_sample) || !sel_legal) begin
                stable_cnt <= sel_legal ? 8'd1 : 8'd0;
            end else if (stable_cnt != STABLE_MAX) begin
                stable_cnt <= stable_cnt + 8'd1;
            end
        end
    end

    // Fires only on the step into saturation, so one capture per stable run
    assign capture = sel_legal && (sample == prev_sample)
                     && (stable_cnt == STABLE_MAX - 8'd1);

    seg7_pattern_decode u_decode (
        .pattern (seg_s),
        .valid   (pat_valid),
        .nibble  (pat_nibble)
    );

    always_comb begin
        accept = 1'b0;
        if (capture) begin
            if (sel_idx == 3'd0) begin
                accept = 1'b1;
            end else if ((state == COLLECT) && (sel_idx == expected)) begin
                accept = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            expected    <= 3'd0;
            digit_buf   <= '0;
            bad         <= 1'b0;
            frame_done  <= 1'b0;
            value_out   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            seq_err     <= 1'b0;

            if (frame_done) begin
                if (!bad) begin
                    value_out   <= digit_buf;
                    frame_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end

            if (accept) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_idx == 3'(i)) begin
                        digit_buf[4*i +: 4] <= pat_nibble;
                    end
                end
            end

            if (capture) begin
                if (sel_idx == 3'd0) begin
                    bad      <= !pat_valid;
                    expected <= 3'd1;
                    if (state == COLLECT) begin
                        seq_err <= 1'b1;
                    end
                    if (NUM_DIGITS == 1) begin
                        frame_done <= 1'b1;
                        state      <= HUNT;
                    end else begin
                        state <= COLLECT;
                    end
                end else if (state == COLLECT) begin
                    if (sel_idx == expected) begin
                        bad      <= bad | !pat_valid;
                        expected <= expected + 3'd1;
                        if (sel_idx == LAST_DIGIT) begin
                            frame_done <= 1'b1;
                            state      <= HUNT;
                        end
                    end else begin
                        seq_err <= 1'b1;
                        state   <= HUNT;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder : directed scans of the display bus with fixed expectations
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] value_out;
    logic        frame_valid;
    logic        frame_err;
    logic        seq_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int se_cnt = 0;
    int fv_cyc = -1;
    int start_cyc = 0;

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .value_out   (value_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt = fv_cnt + 1;
            fv_cyc = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (seq_err)   se_cnt = se_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        fv_cnt = 0;
        fe_cnt = 0;
        se_cnt = 0;
        fv_cyc = -1;
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase
    task automatic show(input int k, input logic [6:0] pat, input int n);
        logic [3:0] one;
        one       = 4'b0001;
        seg_in    = pat;
        dig_sel   = ~(one << k);
        start_cyc = cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        seg_in  = 7'h7F;
        dig_sel = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_value", 32'(value_out), 32'h0);
        check("reset_pulses", {29'd0, frame_valid, frame_err, seq_err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain scan 1,2,3,4 with pulse timing on the last digit
        clr();
        show(0, 7'h79, 10);
        show(1, 7'h24, 10);
        show(2, 7'h30, 10);
        show(3, 7'h19, 10);
        check("scan1_value", 32'(value_out), 32'h4321);
        check("scan1_fv_count", 32'(fv_cnt), 32'd1);
        check("scan1_fv_latency", 32'(fv_cyc - (start_cyc + 1)), 32'd6);
        check("scan1_other_pulses", 32'(fe_cnt + se_cnt), 32'd0);

        // Digit 2 chatters between a good and an undecodable pattern
        clr();
        show(0, 7'h79, 10);
        show(1, 7'h24, 10);
        for (int i = 0; i < 4; i++) begin
            show(2, 7'h30, 3);
            show(2, 7'h31, 3);
        end
        show(2, 7'h30, 10);
        show(3, 7'h19, 10);
        check("bounce_value", 32'(value_out), 32'h4321);
        check("bounce_fv_count", 32'(fv_cnt), 32'd1);
        check("bounce_err_pulses", 32'(fe_cnt + se_cnt), 32'd0);

        // Blank digit makes the frame bad
        clr();
        show(0, 7'h40, 10);
        show(1, 7'h7F, 10);
        show(2, 7'h12, 10);
        show(3, 7'h0E, 10);
        check("bad_value_held", 32'(value_out), 32'h4321);
        check("bad_fe_count", 32'(fe_cnt), 32'd1);
        check("bad_fv_count", 32'(fv_cnt), 32'd0);

        // Out-of-order 0,2 then a stray digit 1 which HUNT ignores
        clr();
        show(0, 7'h08, 10);
        show(2, 7'h46, 10);
        show(1, 7'h03, 10);
        check("order_seq_err", 32'(se_cnt), 32'd1);
        check("order_no_frame", 32'(fv_cnt + fe_cnt), 32'd0);
        show(0, 7'h08, 10);
        show(1, 7'h03, 10);
        show(2, 7'h46, 10);
        show(3, 7'h21, 10);
        check("order_value", 32'(value_out), 32'hDCBA);
        check("order_fv_count", 32'(fv_cnt), 32'd1);

        // Digit 0 re-appearing mid-frame restarts it with seq_err
        clr();
        show(0, 7'h40, 10);
        show(1, 7'h79, 10);
        show(0, 7'h40, 10);
        show(1, 7'h79, 10);
        show(2, 7'h24, 10);
        show(3, 7'h30, 10);
        check("restart_seq_err", 32'(se_cnt), 32'd1);
        check("restart_value", 32'(value_out), 32'h3210);
        check("restart_fv_count", 32'(fv_cnt), 32'd1);

        // Two digits selected at once never captures
        clr();
        seg_in  = 7'h08;
        dig_sel = 4'b1100;
        repeat (20) @(posedge clk);
        #1;
        check("illegal_pulses", 32'(fv_cnt + fe_cnt + se_cnt), 32'd0);
        check("illegal_value", 32'(value_out), 32'h3210);

        // Reset mid-frame discards the partial frame
        clr();
        show(0, 7'h02, 10);
        show(1, 7'h78, 10);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_value", 32'(value_out), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        show(2, 7'h00, 10);
        show(3, 7'h10, 10);
        check("midreset_partial_dropped", 32'(fv_cnt + fe_cnt + se_cnt), 32'd0);
        show(0, 7'h02, 10);
        show(1, 7'h78, 10);
        show(2, 7'h00, 10);
        show(3, 7'h10, 10);
        check("midreset_value_after", 32'(value_out), 32'h9876);
        check("midreset_fv_count", 32'(fv_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
